// File: rtl/txd_pkg.sv
// Shared types and constants for the transmit-buffer write controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package txd_pkg;

  typedef enum logic [1:0] {IDLE, WRITING, DONE} txd_wstate_t;

  localparam int ADDR_W = 8;
  localparam logic [ADDR_W-1:0] MAX_ADDR = 8'd255;

endpackage

// File: rtl/txd_write_fsm_if.sv
// Host-to-buffer write bundle: byte strobes and send request in; write enable, address and frame-done out.
// Latency: n/a (wires only).
// Backpressure: none; a full buffer silently drops writes via wen=0.
interface txd_write_fsm_if;
  import txd_pkg::*;

  logic              XWR;
  logic              XSEND;
  logic              wen;
  logic [ADDR_W-1:0] w_addr;
  logic              done_writing;

  // Host side: drives strobes, observes buffer controls.
  modport master (
    output XWR,
    output XSEND,
    input  wen,
    input  w_addr,
    input  done_writing
  );

  // Controller side.
  modport slave (
    input  XWR,
    input  XSEND,
    output wen,
    output w_addr,
    output done_writing
  );

endinterface

// File: rtl/txd_write_fsm.sv
// Turns host byte strobes into sequential buffer writes and closes a frame with a one-cycle done pulse.
// Latency: wen is combinational (same cycle as XWR); w_addr/done_writing are registered, done one cycle after XSEND.
// Backpressure: none; writes past address 254 are dropped, XWR/XSEND ignored while DONE.
module txd_write_fsm
  import txd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  txd_write_fsm_if.slave   bus
);

  txd_wstate_t       state_q, state_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic              done_q, done_d;
  logic              wen;

  // Write enable: any strobe in IDLE, or in WRITING while the buffer still has room.
  // Address 255 is never written, capping a frame at 255 bytes so w_addr can carry its length.
  always_comb begin
    wen = 1'b0;
    if (bus.XWR) begin
      if (state_q == IDLE) begin
        wen = 1'b1;
      end else if (state_q == WRITING && w_addr_q != MAX_ADDR) begin
        wen = 1'b1;
      end
    end
  end

  // Next-state, address counter and done pulse; a same-cycle write and send still counts the write.
  always_comb begin
    state_d  = state_q;
    w_addr_d = w_addr_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.XWR) begin
          w_addr_d = w_addr_q + 8'd1;
          state_d  = WRITING;
        end
      end
      WRITING: begin
        if (wen) begin
          w_addr_d = w_addr_q + 8'd1;
        end
        if (bus.XSEND) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d  = IDLE;
        w_addr_d = '0;
      end
      default: begin
        state_d  = IDLE;
        w_addr_d = '0;
      end
    endcase
  end

  // State, address and done registers; reset drops any frame in progress without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      w_addr_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_addr_q <= w_addr_d;
      done_q   <= done_d;
    end
  end

  assign bus.wen          = wen;
  assign bus.w_addr       = w_addr_q;
  assign bus.done_writing = done_q;

endmodule

// File: tb/tb_txd_write_fsm.sv
// Directed-vector bench for the transmit-buffer write controller.
// Latency: inputs change 1 time unit after a rising edge; outputs checked at the falling edge.
// Backpressure: n/a.
module tb_txd_write_fsm;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  txd_write_fsm_if bus ();

  txd_write_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, advance past the next edge.
  task automatic step(input logic rst, input logic xwr, input logic xsend,
                      input logic ew, input int ea, input logic ed, input string tag);
    reset     = rst;
    bus.XWR   = xwr;
    bus.XSEND = xsend;
    @(negedge clk);
    chk({tag, ".wen"},  {31'd0, bus.wen},          {31'd0, ew});
    chk({tag, ".addr"}, {24'd0, bus.w_addr},       ea);
    chk({tag, ".done"}, {31'd0, bus.done_writing}, {31'd0, ed});
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    bus.XWR   = 1'b0;
    bus.XSEND = 1'b0;
    @(posedge clk);
    #1;

    // Reset held: everything quiet.
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0, "rst");

    // 20 consecutive writes at 0..19.
    for (int i = 0; i < 20; i++) step(0, 1, 0, 1, i, 0, "burst20");
    step(0, 0, 0, 0, 20, 0, "gap1");
    step(0, 1, 0, 1, 20, 0, "wr20");
    step(0, 0, 0, 0, 21, 0, "gap2");
    // XSEND held three cycles: one pulse only.
    step(0, 0, 1, 0, 21, 0, "send_a");
    step(0, 0, 1, 0, 21, 1, "send_done");
    step(0, 0, 1, 0, 0, 0, "send_idle");
    step(0, 0, 0, 0, 0, 0, "send_after");

    // Write and send in the same cycle after 3 writes.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, i, 0, "pre3");
    step(0, 1, 1, 1, 3, 0, "wr_send");
    step(0, 1, 0, 0, 4, 1, "ws_done");   // XWR ignored while DONE
    step(0, 0, 0, 0, 0, 0, "ws_idle");

    // Overflow: only 0..254 written, address pinned at 255.
    for (int i = 0; i < 300; i++) begin
      if (i < 255) step(0, 1, 0, 1, i, 0, "fill");
      else         step(0, 1, 0, 0, 255, 0, "full");
    end
    step(0, 0, 1, 0, 255, 0, "full_send");
    step(0, 0, 0, 0, 255, 1, "full_done");
    step(0, 0, 0, 0, 0, 0, "full_idle");

    // Reset mid-frame discards it.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1, i, 0, "pre_rst");
    step(1, 0, 0, 0, 5, 0, "mid_rst");
    step(0, 0, 1, 0, 0, 0, "rst_send");
    step(0, 0, 0, 0, 0, 0, "rst_nodone");
    step(0, 1, 0, 1, 0, 0, "rst_wr0");
    step(0, 0, 0, 0, 1, 0, "rst_wr1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
